// File: rtl/branch_fwd_ctrl.sv
// Forwarding/hazard controller for the decode-stage branch comparator.
// Shadows E/M/W destination state to pick branch operand sources and stall on load-use.
module branch_fwd_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_d,
   input  logic             branch_d,
   input  logic             use_rs1_d,
   input  logic             use_rs2_d,
   input  logic [REG_W-1:0] rs1_d,
   input  logic [REG_W-1:0] rs2_d,
   input  logic [REG_W-1:0] rd_d,
   input  logic             regwrite_d,
   input  logic             load_d,
   input  logic             flush_d,
   input  logic             mem_stall,
   output logic [1:0]       sel_a,
   output logic [1:0]       sel_b,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_e,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             r_vld_e, r_wr_e, r_ld_e;
   logic             r_vld_m, r_wr_m, r_ld_m;
   logic             r_vld_w, r_wr_w;
   logic [REG_W-1:0] r_rd_e, r_rd_m, r_rd_w;
   logic [CNT_W-1:0] r_cnt;

   logic w_e_a, w_m_a, w_w_a;
   logic w_e_b, w_m_b, w_w_b;
   logic w_hz_a, w_hz_b, w_hz;

   // Producer matches; x0 is never a producer.
   always_comb begin
      w_e_a = r_vld_e & r_wr_e & (r_rd_e == rs1_d) & (rs1_d != '0);
      w_m_a = r_vld_m & r_wr_m & (r_rd_m == rs1_d) & (rs1_d != '0);
      w_w_a = r_vld_w & r_wr_w & (r_rd_w == rs1_d) & (rs1_d != '0);
      w_e_b = r_vld_e & r_wr_e & (r_rd_e == rs2_d) & (rs2_d != '0);
      w_m_b = r_vld_m & r_wr_m & (r_rd_m == rs2_d) & (rs2_d != '0);
      w_w_b = r_vld_w & r_wr_w & (r_rd_w == rs2_d) & (rs2_d != '0);
   end

   // Youngest producer wins; a pending load selects the register file while the stall covers it.
   always_comb begin
      sel_a = 2'b00;
      if (w_e_a)      sel_a = r_ld_e ? 2'b00 : 2'b11;
      else if (w_m_a) sel_a = r_ld_m ? 2'b00 : 2'b10;
      else if (w_w_a) sel_a = 2'b01;

      sel_b = 2'b00;
      if (w_e_b)      sel_b = r_ld_e ? 2'b00 : 2'b11;
      else if (w_m_b) sel_b = r_ld_m ? 2'b00 : 2'b10;
      else if (w_w_b) sel_b = 2'b01;
   end

   always_comb begin
      w_hz_a = use_rs1_d & ((w_e_a & r_ld_e) | (w_m_a & r_ld_m));
      w_hz_b = use_rs2_d & ((w_e_b & r_ld_e) | (w_m_b & r_ld_m));
      w_hz   = valid_d & branch_d & (w_hz_a | w_hz_b);
   end

   assign stall_f   = w_hz | mem_stall;
   assign stall_d   = w_hz | mem_stall;
   assign flush_e   = w_hz & ~mem_stall;
   assign stall_cnt = r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_e <= 1'b0; r_wr_e <= 1'b0; r_ld_e <= 1'b0; r_rd_e <= '0;
         r_vld_m <= 1'b0; r_wr_m <= 1'b0; r_ld_m <= 1'b0; r_rd_m <= '0;
         r_vld_w <= 1'b0; r_wr_w <= 1'b0; r_rd_w <= '0;
         r_cnt   <= '0;
      end else if (!mem_stall) begin
         r_vld_w <= r_vld_m; r_wr_w <= r_wr_m; r_rd_w <= r_rd_m;
         r_vld_m <= r_vld_e; r_wr_m <= r_wr_e; r_ld_m <= r_ld_e; r_rd_m <= r_rd_e;
         r_vld_e <= valid_d & ~flush_d & ~w_hz;
         r_wr_e  <= regwrite_d;
         r_ld_e  <= load_d;
         r_rd_e  <= rd_d;
         if (w_hz && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_fwd_ctrl.sv
// Directed bench for branch_fwd_ctrl; a second instance with a 4-bit counter checks saturation.
module tb_branch_fwd_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       valid_d = 1'b0, branch_d = 1'b0, use_rs1_d = 1'b0, use_rs2_d = 1'b0;
   logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
   logic       regwrite_d = 1'b0, load_d = 1'b0, flush_d = 1'b0, mem_stall = 1'b0;
   logic [1:0] sel_a, sel_b, s_sel_a, s_sel_b;
   logic       stall_f, stall_d, flush_e, s_stall_f, s_stall_d, s_flush_e;
   logic [31:0] stall_cnt;
   logic [3:0]  s_stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_fwd_ctrl #(.REG_W(5), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .valid_d(valid_d), .branch_d(branch_d),
      .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .flush_d(flush_d),
      .mem_stall(mem_stall), .sel_a(sel_a), .sel_b(sel_b), .stall_f(stall_f),
      .stall_d(stall_d), .flush_e(flush_e), .stall_cnt(stall_cnt)
   );

   branch_fwd_ctrl #(.REG_W(5), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .valid_d(valid_d), .branch_d(branch_d),
      .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .flush_d(flush_d),
      .mem_stall(mem_stall), .sel_a(s_sel_a), .sel_b(s_sel_b), .stall_f(s_stall_f),
      .stall_d(s_stall_d), .flush_e(s_flush_e), .stall_cnt(s_stall_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_d(input logic v, input logic br, input logic u1, input logic u2,
                          input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                          input logic rw, input logic ld, input logic fl);
      valid_d = v; branch_d = br; use_rs1_d = u1; use_rs2_d = u2;
      rs1_d = s1; rs2_d = s2; rd_d = d; regwrite_d = rw; load_d = ld; flush_d = fl;
      #1;
   endtask

   task automatic nop_d();
      drive_d(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      mem_stall = 1'b0;
      nop_d();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nop_d();
      n_tests++;
      if ({sel_a, sel_b} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_sel: got %b/%b expected 00/00", sel_a, sel_b);
      end
      n_tests++;
      if ({stall_f, stall_d, flush_e} !== 3'b000) begin
         n_fail++; $display("FAIL reset_stall: got %b expected 000", {stall_f, stall_d, flush_e});
      end
      n_tests++;
      if (stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
      end
   endtask

   task automatic test_alu_b2b();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); // add x5
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0); // beq x5,x6
      n_tests++;
      if ({sel_a, sel_b} !== 4'b1100) begin
         n_fail++; $display("FAIL alu_e_sel: got %b/%b expected 11/00", sel_a, sel_b);
      end
      n_tests++;
      if ({stall_f, stall_d, flush_e} !== 3'b000) begin
         n_fail++; $display("FAIL alu_e_nostall: got %b expected 000", {stall_f, stall_d, flush_e});
      end
      step();
      n_tests++;
      if (sel_a !== 2'b10) begin
         n_fail++; $display("FAIL alu_m_sel_a: got %b expected 10", sel_a);
      end
      step();
      n_tests++;
      if (sel_a !== 2'b01) begin
         n_fail++; $display("FAIL alu_w_sel_a: got %b expected 01", sel_a);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0); // lw x7
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); // beq x7,x0
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if ({stall_f, stall_d, flush_e} !== 3'b111) begin
            n_fail++; $display("FAIL lu_stall%0d: got %b expected 111", i, {stall_f, stall_d, flush_e});
         end
         step();
      end
      n_tests++;
      if ({stall_f, stall_d, flush_e} !== 3'b000) begin
         n_fail++; $display("FAIL lu_release: got %b expected 000", {stall_f, stall_d, flush_e});
      end
      n_tests++;
      if ({sel_a, sel_b} !== 4'b0100) begin
         n_fail++; $display("FAIL lu_sel: got %b/%b expected 01/00", sel_a, sel_b);
      end
      n_tests++;
      if (stall_cnt !== 32'd2) begin
         n_fail++; $display("FAIL lu_cnt: got %0d expected 2", stall_cnt);
      end
   endtask

   task automatic test_double_producer();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
      step();
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({sel_a, sel_b} !== 4'b1111) begin
         n_fail++; $display("FAIL double_sel: got %b/%b expected 11/11", sel_a, sel_b);
      end
   endtask

   task automatic test_x0_nonbranch();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); // add x0
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({sel_a, sel_b, stall_f, flush_e} !== 6'b000000) begin
         n_fail++; $display("FAIL x0: got sel %b/%b stall %b flush %b expected all 0", sel_a, sel_b, stall_f, flush_e);
      end
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0); // lw x4
      step();
      drive_d(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0); // add using x4
      n_tests++;
      if ({stall_f, stall_d, flush_e} !== 3'b000) begin
         n_fail++; $display("FAIL nonbranch_nostall: got %b expected 000", {stall_f, stall_d, flush_e});
      end
   endtask

   task automatic test_mem_stall();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      mem_stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({stall_f, stall_d, flush_e} !== 3'b110) begin
            n_fail++; $display("FAIL ms_hold%0d: got %b expected 110", i, {stall_f, stall_d, flush_e});
         end
         step();
      end
      n_tests++;
      if (stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL ms_cnt_frozen: got %0d expected 0", stall_cnt);
      end
      mem_stall = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if ({stall_f, stall_d, flush_e} !== 3'b111) begin
            n_fail++; $display("FAIL ms_hz%0d: got %b expected 111", i, {stall_f, stall_d, flush_e});
         end
         step();
      end
      n_tests++;
      if ({stall_f, flush_e, sel_a} !== 4'b0001) begin
         n_fail++; $display("FAIL ms_release: got stall %b flush %b sel_a %b expected 0 0 01", stall_f, flush_e, sel_a);
      end
      n_tests++;
      if (stall_cnt !== 32'd2) begin
         n_fail++; $display("FAIL ms_cnt: got %0d expected 2", stall_cnt);
      end
   endtask

   task automatic test_flush_hz();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if ({stall_f, stall_d, flush_e} !== 3'b111) begin
         n_fail++; $display("FAIL flush_hz: got %b expected 111", {stall_f, stall_d, flush_e});
      end
      step();
      n_tests++;
      if ({stall_f, flush_e, stall_cnt} !== {2'b11, 32'd1}) begin
         n_fail++; $display("FAIL flush_hz_m: got stall %b flush %b cnt %0d expected 1 1 1", stall_f, flush_e, stall_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      step();
      drive_d(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      n_tests++;
      if ({sel_a, sel_b, stall_f, stall_d, flush_e} !== 7'b0) begin
         n_fail++; $display("FAIL reset_mid: got sel %b/%b stalls %b expected 0", sel_a, sel_b, {stall_f, stall_d, flush_e});
      end
      n_tests++;
      if (stall_cnt !== 32'd0) begin
         n_fail++; $display("FAIL reset_mid_cnt: got %0d expected 0", stall_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int r = 0; r < 10; r++) begin
         drive_d(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
         step();
         drive_d(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
         step();
         step();
         step();
      end
      n_tests++;
      if (s_stall_cnt !== 4'd15) begin
         n_fail++; $display("FAIL sat_small: got %0d expected 15", s_stall_cnt);
      end
      n_tests++;
      if (stall_cnt !== 32'd20) begin
         n_fail++; $display("FAIL sat_wide: got %0d expected 20", stall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_alu_b2b();
      test_load_use();
      test_double_producer();
      test_x0_nonbranch();
      test_mem_stall();
      test_flush_hz();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_fwd_ctrl.md
Name: branch_fwd_ctrl

Overview:
Forwarding and hazard controller for the decode-stage branch comparator of the pipelined RV32I core. It tracks in-flight destination registers in its own shadow E/M/W pipeline and drives the two 2-bit select inputs of the branch source muxes. When a branch operand depends on a load whose data is not yet available, it stalls F/D and injects a bubble into E. It also keeps a saturating count of branch stall cycles for performance monitoring.

Parameters:
REG_W, 5, register index width
CNT_W, 32, width of branch-stall performance counter

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
valid_d  input  1  D-stage instruction valid
branch_d  input  1  D instruction is a branch/JALR that needs its operands compared in D
use_rs1_d  input  1  D instruction reads rs1
use_rs2_d  input  1  D instruction reads rs2
rs1_d  input  REG_W  source register 1 index in D
rs2_d  input  REG_W  source register 2 index in D
rd_d  input  REG_W  destination register index in D
regwrite_d  input  1  D instruction writes rd
load_d  input  1  D instruction is a load (result ready only in W)
flush_d  input  1  squash the D instruction; it does not advance to E
mem_stall  input  1  global freeze from memory; whole pipeline holds
sel_a  output  2  branch source mux select, operand A (rs1)
sel_b  output  2  branch source mux select, operand B (rs2)
stall_f  output  1  hold PC/F stage
stall_d  output  1  hold F/D register
flush_e  output  1  insert bubble into D/E register
stall_cnt  output  CNT_W  count of hazard stall cycles

Behaviour:
- Select encoding (fixed): 00 = register-file value, 01 = W-stage result, 10 = M-stage ALU result, 11 = E-stage ALU result.
- Shadow state per stage E, M, W: vld, rd, wr, ld. A stage is a producer for register r when vld & wr & rd == r & r != 0.
- Advance each cycle when mem_stall = 0:
  - W <= M, M <= E.
  - E <= D fields, with vld_e = valid_d & ~flush_d & ~hz.
  - hz is the internal load-use hazard defined below.
- When mem_stall = 1, all shadow registers hold.
- Select for each operand (rs1 -> sel_a, rs2 -> sel_b) is combinational from shadow state. Youngest producer wins:
  - E producer: 11 if ~ld_e, else 00 (stall covers it).
  - M producer: 10 if ~ld_m, else 00.
  - W producer: 01.
  - Otherwise, or index 0: 00.
  - Selects are computed regardless of valid_d or branch_d.
- hz = valid_d & branch_d & (for any used operand: an E producer with ld_e, or an M producer with ld_m).
- Stall outputs:
  - stall_f = stall_d = hz | mem_stall.
  - flush_e = hz & ~mem_stall.
- Latency for a load producer followed immediately by a dependent branch: 2 stall cycles, then sel = 01.
- Latency for a load two instructions ahead: 1 stall cycle, then sel = 01.
- ALU producers never stall.
- stall_cnt increments by 1 on each clock where hz = 1 and mem_stall = 0. It saturates at all-ones.
- Simultaneous events:
  - flush_d and hz together: flush_e = 1, E receives a bubble, stalls still asserted.
  - mem_stall dominates hz: no bubble, counter frozen.
- Reset (synchronous): all shadow vld = 0, rd/wr/ld = 0, stall_cnt = 0. Consequently sel_a = sel_b = 00 and stall_f/stall_d/flush_e = 0 from the first cycle after reset.
- Reset mid-stall: all pending hazards are discarded on the next edge.
- x0 is never forwarded and never causes a stall.

Test Plan:
- ALU back-to-back: cycle0 D = add x5 (regwrite_d = 1, rd_d = 5); cycle1 D = beq x5,x6 -> sel_a = 11, sel_b = 00, no stall; cycle2 (same beq held) -> sel_a = 10.
- Load-use: lw x7 then beq x7,x0 -> stall_f = stall_d = flush_e = 1 for exactly 2 cycles, then sel_a = 01 with no stall; stall_cnt = 2.
- Double producer: E = add x3, M = add x3, D beq x3,x3 -> sel_a = sel_b = 11 (youngest wins).
- x0 and non-branch: add x0 in E, D beq x0,x0 -> sel 00, no stall. lw x4 in E with D = add using x4 (branch_d = 0) -> no stall.
- mem_stall during load-use: hold mem_stall = 1 for 3 cycles while lw x7 sits in E -> flush_e = 0, shadow frozen, stall_cnt unchanged. After release -> 2 hazard cycles as normal.
- Reset asserted mid-hazard -> next cycle all selects 00, stalls 0, stall_cnt = 0. Counter saturation with CNT_W = 4: 20 hazard cycles -> stall_cnt = 15.
